// File: rtl/pipe_rr_arb.sv
// Round-robin arbiter sharing one registered pipeline stage between NREQ
// requesters. A grant is held for a whole packet (LOCK) and a watchdog
// force-releases a lock whose owner stops sending beats.
module pipe_rr_arb #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int DSIZE   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_rdy,
  input  logic                  ds_ready,
  output logic                  out_vld,
  output logic [DSIZE-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  out_last,
  output logic                  err_timeout
);

  typedef enum logic {IDLE, LOCK} state_t;

  localparam bit          WD_EN   = (TIMEOUT != 0);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]   lock_id, lock_id_nxt;
  logic [15:0]      wd_cnt, wd_cnt_nxt;
  logic             err_nxt;

  logic             found;
  logic [IDW-1:0]   winner;
  logic             load_ok;
  logic             accept;
  logic [DSIZE-1:0] win_data;
  logic             win_last;

  // Successor of a requester index, wrapping at NREQ (not at 2**IDW).
  function automatic logic [IDW-1:0] inc_mod(input logic [IDW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  assign load_ok  = !out_vld || ds_ready;
  assign accept   = load_ok && found;
  assign win_data = req_data[int'(winner)*DSIZE +: DSIZE];
  assign win_last = req_last[winner];

  // Pick the eligible winner: the lock owner in LOCK, else first valid from rr_ptr upward.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    found  = 1'b0;
    winner = '0;
    idx_search: begin
      int idx;
      idx = 0;
      if (state == LOCK) begin
        found  = req_vld[lock_id];
        winner = lock_id;
      end else begin
        for (int k = 0; k < NREQ; k++) begin
          idx = int'(rr_ptr) + k;
          if (idx >= NREQ) idx = idx - NREQ;
          if (!found && req_vld[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
          end
        end
      end
    end
  end

  // One-hot ready toward the granted requester, only when the output can load.
  always_comb begin
    req_rdy = '0;
    if (accept) req_rdy[winner] = 1'b1;
  end

  // Next-state logic: packet lock/unlock, pointer rotation and watchdog.
  always_comb begin
    state_nxt   = state;
    rr_ptr_nxt  = rr_ptr;
    lock_id_nxt = lock_id;
    wd_cnt_nxt  = wd_cnt;
    err_nxt     = 1'b0;
    if (accept) begin
      wd_cnt_nxt = '0;
      if (win_last) begin
        state_nxt  = IDLE;
        rr_ptr_nxt = inc_mod(winner);
      end else begin
        state_nxt   = LOCK;
        lock_id_nxt = winner;
      end
    end else if (state == LOCK) begin
      if (WD_EN && wd_cnt == WD_LAST) begin
        state_nxt  = IDLE;
        rr_ptr_nxt = inc_mod(lock_id);
        err_nxt    = 1'b1;
        wd_cnt_nxt = '0;
      end else if (wd_cnt != 16'hFFFF) begin
        wd_cnt_nxt = wd_cnt + 16'd1;
      end
    end else begin
      wd_cnt_nxt = '0;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lock_id     <= '0;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      lock_id     <= lock_id_nxt;
      wd_cnt      <= wd_cnt_nxt;
      err_timeout <= err_nxt;
    end
  end

  // Output pipeline register: load on accept, clear on drain, hold under backpressure.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_id   <= '0;
      out_last <= 1'b0;
    end else if (accept) begin
      out_vld  <= 1'b1;
      out_data <= win_data;
      out_id   <= winner;
      out_last <= win_last;
    end else if (ds_ready) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_rr_arb.sv
// Self-checking bench for pipe_rr_arb: a cycle-level behavioural model is
// compared against the DUT every cycle, and directed scenarios pin the
// model with hand-computed literal expectations.
module tb_pipe_rr_arb;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int DSIZE   = 8;
  localparam int TIMEOUT = 8;

  logic                  clock;
  logic                  rst_n;
  logic [NREQ-1:0]       req_vld;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_rdy;
  logic                  ds_ready;
  logic                  out_vld;
  logic [DSIZE-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_last;
  logic                  err_timeout;

  pipe_rr_arb #(
    .NREQ(NREQ), .IDW(IDW), .DSIZE(DSIZE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .rst_n(rst_n),
    .req_vld(req_vld), .req_data(req_data), .req_last(req_last),
    .req_rdy(req_rdy), .ds_ready(ds_ready),
    .out_vld(out_vld), .out_data(out_data), .out_id(out_id),
    .out_last(out_last), .err_timeout(err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  bit         m_vld    = 1'b0;
  logic [7:0] m_data   = '0;
  int         m_id     = 0;
  bit         m_last   = 1'b0;
  bit         m_err    = 1'b0;
  bit         m_locked = 1'b0;
  int         m_owner  = 0;
  int         m_ptr    = 0;
  int         m_idle   = 0;

  // Requester the rules allow to go this cycle, or -1 if none.
  function automatic int pick();
    if (m_locked) return req_vld[m_owner] ? m_owner : -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_vld[i]) return i;
    end
    return -1;
  endfunction

  // Compare at the falling edge, then advance the model to the state the
  // next rising edge will produce (inputs only change just after rising edges).
  always @(negedge clock) begin
    if (chk_en) begin
      int  g;
      bit  lok;
      bit  acc;
      logic [NREQ-1:0] exp_rdy;
      g       = pick();
      lok     = !m_vld || ds_ready;
      acc     = lok && (g >= 0);
      exp_rdy = acc ? NREQ'(1 << g) : '0;
      check("m_req_rdy",  req_rdy,     exp_rdy);
      check("m_out_vld",  out_vld,     m_vld);
      check("m_out_data", out_data,    m_data);
      check("m_out_id",   out_id,      m_id);
      check("m_out_last", out_last,    m_last);
      check("m_err",      err_timeout, m_err);
      if (!rst_n) begin
        m_vld = 0; m_data = 0; m_id = 0; m_last = 0; m_err = 0;
        m_locked = 0; m_owner = 0; m_ptr = 0; m_idle = 0;
      end else begin
        m_err = 0;
        if (acc) begin
          m_vld  = 1;
          m_data = req_data[g*DSIZE +: DSIZE];
          m_id   = g;
          m_last = req_last[g];
          m_idle = 0;
          if (req_last[g]) begin
            m_locked = 0;
            m_ptr    = (g + 1) % NREQ;
          end else begin
            m_locked = 1;
            m_owner  = g;
          end
        end else begin
          if (ds_ready) begin
            m_vld = 0; m_data = 0; m_last = 0;
          end
          if (m_locked) begin
            if (m_idle == TIMEOUT - 1) begin
              m_locked = 0;
              m_ptr    = (m_owner + 1) % NREQ;
              m_err    = 1;
              m_idle   = 0;
            end else begin
              m_idle++;
            end
          end else begin
            m_idle = 0;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int exp_ids [5] = '{0, 1, 2, 3, 0};

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic [7:0] d, input logic l);
    req_vld[i]                = v;
    req_data[i*DSIZE +: DSIZE] = d;
    req_last[i]               = l;
  endtask

  initial begin
    #100000;
    $display("FAIL time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n    = 1'b0;
    ds_ready = 1'b0;
    req_vld  = '0;
    req_data = '0;
    req_last = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    cyc();
    check("rst_out_vld",  out_vld,     0);
    check("rst_out_data", out_data,    0);
    check("rst_out_id",   out_id,      0);
    check("rst_out_last", out_last,    0);
    check("rst_err",      err_timeout, 0);

    // Rotation: all four send single-beat packets back to back.
    rst_n    = 1'b1;
    ds_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) drive(i, 1'b1, 8'(8'h10 + i), 1'b1);
    #1;
    check("rr_first_rdy", req_rdy, 4'b0001);
    check("rr_c1_vld",    out_vld, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("rr_vld",  out_vld,  1);
      check("rr_id",   out_id,   exp_ids[k]);
      check("rr_data", out_data, 8'(8'h10 + exp_ids[k]));
    end

    // Three-beat packet from req 2 while req 0 and 1 keep requesting.
    drive(0, 1'b1, 8'h20, 1'b1);
    drive(1, 1'b1, 8'h21, 1'b1);
    drive(2, 1'b1, 8'hA1, 1'b0);
    drive(3, 1'b0, 8'h00, 1'b0);
    cyc();
    check("pkt_pre_id",   out_id,   1);
    check("pkt_pre_data", out_data, 8'h21);
    cyc();
    check("pkt_a1_data", out_data, 8'hA1);
    check("pkt_a1_id",   out_id,   2);
    check("pkt_a1_last", out_last, 0);
    drive(2, 1'b1, 8'hA2, 1'b0);
    #1;
    check("pkt_lock_rdy", req_rdy, 4'b0100);
    cyc();
    check("pkt_a2_data", out_data, 8'hA2);
    check("pkt_a2_id",   out_id,   2);
    drive(2, 1'b1, 8'hA3, 1'b1);
    cyc();
    check("pkt_a3_data", out_data, 8'hA3);
    check("pkt_a3_last", out_last, 1);
    check("pkt_a3_id",   out_id,   2);
    drive(2, 1'b0, 8'h00, 1'b0);
    #1;
    check("pkt_next_rdy", req_rdy, 4'b0001);
    cyc();
    check("pkt_next_id",   out_id,   0);
    check("pkt_next_data", out_data, 8'h20);

    // Backpressure: hold 0x5C for five cycles, then drain and reload on one edge.
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    drive(3, 1'b1, 8'h5C, 1'b1);
    cyc();
    check("bp_load_data", out_data, 8'h5C);
    ds_ready = 1'b0;
    drive(3, 1'b1, 8'h5D, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rdy", req_rdy, 0);
      cyc();
      check("bp_hold_data", out_data, 8'h5C);
      check("bp_hold_vld",  out_vld,  1);
    end
    ds_ready = 1'b1;
    #1;
    check("bp_release_rdy", req_rdy, 4'b1000);
    cyc();
    check("bp_next_vld",  out_vld,  1);
    check("bp_next_data", out_data, 8'h5D);
    check("bp_next_id",   out_id,   3);

    // Watchdog: req 1 opens a packet and goes silent; req 2 is waiting.
    drive(3, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b1, 8'h31, 1'b0);
    drive(2, 1'b1, 8'h42, 1'b1);
    #1;
    check("wd_open_rdy", req_rdy, 4'b0010);
    cyc();
    check("wd_open_data", out_data, 8'h31);
    drive(1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < TIMEOUT; k++) begin
      #1;
      check("wd_wait_rdy", req_rdy,     0);
      check("wd_wait_err", err_timeout, 0);
      cyc();
    end
    check("wd_pulse",     err_timeout, 1);
    check("wd_grant_rdy", req_rdy,     4'b0100);
    cyc();
    check("wd_pulse_end", err_timeout, 0);
    check("wd_grant_id",  out_id,      2);
    check("wd_grant_dat", out_data,    8'h42);
    drive(2, 1'b0, 8'h00, 1'b0);

    // Reset in the middle of a packet from req 3.
    drive(3, 1'b1, 8'h71, 1'b0);
    cyc();
    check("mr_lock_data", out_data, 8'h71);
    check("mr_lock_id",   out_id,   3);
    drive(3, 1'b1, 8'h72, 1'b0);
    drive(0, 1'b1, 8'h0A, 1'b1);
    rst_n = 1'b0;
    cyc();
    check("mr_vld",  out_vld,  0);
    check("mr_data", out_data, 0);
    check("mr_id",   out_id,   0);
    check("mr_last", out_last, 0);
    rst_n = 1'b1;
    #1;
    check("mr_first_rdy", req_rdy, 4'b0001);
    cyc();
    check("mr_first_id",   out_id,   0);
    check("mr_first_data", out_data, 8'h0A);

    req_vld = '0;
    cyc();
    cyc();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
